// File: rtl/note_lane_renderer.sv
// Note-highway renderer: per-lane shift registers advanced by song steps, plus a
// snapshot rasteriser that streams solid boxes to the VGA plotter over a valid/ready handshake.
module note_lane_renderer #(
  parameter int LANES      = 3,
  parameter int DEPTH      = 4,
  parameter int BOX_W      = 8,
  parameter int BOX_H      = 8,
  parameter int LANE_PITCH = 10,
  parameter int SLOT_PITCH = 24,
  parameter int ORIGIN_X   = 0,
  parameter int ORIGIN_Y   = 120,
  parameter int X_W        = 9,
  parameter int Y_W        = 8,
  parameter logic [2:0] NOTE_COLOUR = 3'b111,
  parameter logic [2:0] HIT_COLOUR  = 3'b010,
  parameter logic [2:0] BG_COLOUR   = 3'b000,
  parameter logic [LANES*DEPTH-1:0] RESET_PATTERN = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             shift,
  input  logic             loop_mode,
  input  logic [LANES-1:0] new_notes,
  output logic [LANES-1:0] hit_notes,
  output logic             hit_valid,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [X_W-1:0]   pix_x,
  output logic [Y_W-1:0]   pix_y,
  output logic [2:0]       pix_colour
);

  // state    | meaning
  // stIdle   | waiting for start; snapshot taken when it arrives
  // stDraw   | streaming snapshot pixels, one per accepted handshake
  // stDone   | single-cycle done pulse before returning to idle
  typedef enum logic [1:0] {stIdle, stDraw, stDone} stateT;

  localparam int DW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int RW = (BOX_H > 1) ? $clog2(BOX_H) : 1;
  localparam int CW = (BOX_W > 1) ? $clog2(BOX_W) : 1;

  stateT state;
  logic grid [LANES][DEPTH];
  logic snap [LANES][DEPTH];

  logic [DW-1:0] dIdx, nD;
  logic [LW-1:0] lIdx, nL;
  logic [RW-1:0] rIdx, nR;
  logic [CW-1:0] cIdx, nC;
  logic          lastPix;

  function automatic logic [X_W-1:0] xOf(input logic [LW-1:0] l, input logic [CW-1:0] c);
    return X_W'(ORIGIN_X + int'(l) * LANE_PITCH + int'(c));
  endfunction

  function automatic logic [Y_W-1:0] yOf(input logic [DW-1:0] d, input logic [RW-1:0] r);
    return Y_W'(ORIGIN_Y + int'(d) * SLOT_PITCH + int'(r));
  endfunction

  function automatic logic [2:0] colourOf(input logic note, input logic [DW-1:0] d);
    if (!note)                  return BG_COLOUR;
    else if (d == DW'(DEPTH-1)) return HIT_COLOUR;
    else                        return NOTE_COLOUR;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_notes <= '0;
      hit_valid <= 1'b0;
      for (int l = 0; l < LANES; l++)
        for (int d = 0; d < DEPTH; d++)
          grid[l][d] <= RESET_PATTERN[l*DEPTH + d];
    end else begin
      hit_valid <= shift;
      if (shift) begin
        for (int l = 0; l < LANES; l++) begin
          hit_notes[l] <= grid[l][DEPTH-1];
          for (int d = 1; d < DEPTH; d++)
            grid[l][d] <= grid[l][d-1];
          grid[l][0] <= loop_mode ? grid[l][DEPTH-1] : new_notes[l];
        end
      end
    end
  end

  // Raster order, innermost first: column, row, lane, slot.
  always_comb begin
    nC      = cIdx + CW'(1);
    nR      = rIdx;
    nL      = lIdx;
    nD      = dIdx;
    lastPix = 1'b0;
    if (cIdx == CW'(BOX_W-1)) begin
      nC = '0;
      nR = rIdx + RW'(1);
      if (rIdx == RW'(BOX_H-1)) begin
        nR = '0;
        nL = lIdx + LW'(1);
        if (lIdx == LW'(LANES-1)) begin
          nL = '0;
          nD = dIdx + DW'(1);
          if (dIdx == DW'(DEPTH-1)) begin
            nD      = '0;
            lastPix = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= stIdle;
      busy       <= 1'b0;
      done       <= 1'b0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_colour <= '0;
      dIdx       <= '0;
      lIdx       <= '0;
      rIdx       <= '0;
      cIdx       <= '0;
      for (int l = 0; l < LANES; l++)
        for (int d = 0; d < DEPTH; d++)
          snap[l][d] <= 1'b0;
    end else begin
      case (state)
        stIdle: begin
          done <= 1'b0;
          if (start) begin
            // grid here is the pre-shift value even if shift fires this cycle
            for (int l = 0; l < LANES; l++)
              for (int d = 0; d < DEPTH; d++)
                snap[l][d] <= grid[l][d];
            dIdx       <= '0;
            lIdx       <= '0;
            rIdx       <= '0;
            cIdx       <= '0;
            pix_x      <= xOf('0, '0);
            pix_y      <= yOf('0, '0);
            pix_colour <= colourOf(grid[0][0], '0);
            busy       <= 1'b1;
            pix_valid  <= 1'b1;
            state      <= stDraw;
          end
        end
        stDraw: begin
          if (pix_ready) begin
            if (lastPix) begin
              pix_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= stDone;
            end else begin
              dIdx       <= nD;
              lIdx       <= nL;
              rIdx       <= nR;
              cIdx       <= nC;
              pix_x      <= xOf(nL, nC);
              pix_y      <= yOf(nD, nR);
              pix_colour <= colourOf(snap[nL][nD], nD);
            end
          end
        end
        stDone: begin
          done  <= 1'b0;
          state <= stIdle;
        end
        default: state <= stIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_note_lane_renderer.sv
// Scoreboard bench for note_lane_renderer: a grid model queues the expected frame
// at start, and each accepted pixel is popped and compared.
module tb_note_lane_renderer;
  localparam int LANES = 3;
  localparam int DEPTH = 4;
  localparam int BOX_W = 8;
  localparam int BOX_H = 8;
  localparam int N     = LANES * DEPTH * BOX_H * BOX_W;
  localparam logic [11:0] RST_PAT = 12'b1000_0100_0010;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       shift = 1'b0;
  logic       loop_mode = 1'b0;
  logic [2:0] new_notes = 3'b000;
  logic [2:0] hit_notes;
  logic       hit_valid;
  logic       start = 1'b0;
  logic       busy;
  logic       done;
  logic       pix_valid;
  logic       pix_ready = 1'b0;
  logic [8:0] pix_x;
  logic [7:0] pix_y;
  logic [2:0] pix_colour;

  int checks = 0;
  int failures = 0;
  int hvCount = 0;
  int hitPixCount = 0;
  logic [11:0] mg;
  logic [19:0] sbQ[$];
  logic [2:0]  hGot;

  note_lane_renderer #(.RESET_PATTERN(RST_PAT)) dut (
    .clock(clock), .reset(reset), .shift(shift), .loop_mode(loop_mode),
    .new_notes(new_notes), .hit_notes(hit_notes), .hit_valid(hit_valid),
    .start(start), .busy(busy), .done(done), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour)
  );

  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelShift(input bit lp, input logic [2:0] nn, output logic [2:0] h);
    logic top;
    for (int l = 0; l < LANES; l++) begin
      h[l] = mg[l*DEPTH + DEPTH-1];
      top  = lp ? mg[l*DEPTH + DEPTH-1] : nn[l];
      for (int d = DEPTH-1; d >= 1; d--)
        mg[l*DEPTH + d] = mg[l*DEPTH + d-1];
      mg[l*DEPTH] = top;
    end
  endtask

  task automatic pushFrame();
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] col;
    for (int d = 0; d < DEPTH; d++)
      for (int l = 0; l < LANES; l++)
        for (int r = 0; r < BOX_H; r++)
          for (int c = 0; c < BOX_W; c++) begin
            x   = 9'(l*10 + c);
            y   = 8'(120 + d*24 + r);
            col = !mg[l*DEPTH + d] ? 3'b000 : (d == DEPTH-1) ? 3'b010 : 3'b111;
            sbQ.push_back({x, y, col});
          end
  endtask

  task automatic doShift(input bit lp, input logic [2:0] nn, output logic [2:0] hObs);
    logic [2:0] hExp;
    shift = 1'b1; loop_mode = lp; new_notes = nn;
    modelShift(lp, nn, hExp);
    @(negedge clock);
    shift = 1'b0; new_notes = 3'b000;
    checkVal("shift_hv", hit_valid, 1);
    checkVal("shift_hit", hit_notes, hExp);
    hvCount += int'(hit_valid);
    hObs = hit_notes;
    @(negedge clock);
    checkVal("hv_pulse", hit_valid, 0);
  endtask

  task automatic loadGrid(input logic [11:0] pat);
    logic [2:0] nn, hExp;
    for (int k = 0; k < DEPTH; k++) begin
      for (int l = 0; l < LANES; l++) nn[l] = pat[l*DEPTH + DEPTH-1-k];
      shift = 1'b1; loop_mode = 1'b0; new_notes = nn;
      modelShift(1'b0, nn, hExp);
      @(negedge clock);
      checkVal("load_hv", hit_valid, 1);
      checkVal("load_hit", hit_notes, hExp);
    end
    shift = 1'b0; new_notes = 3'b000;
    @(negedge clock);
    checkVal("load_hv_end", hit_valid, 0);
  endtask

  task automatic runDraw(input bit randReady, input bit shiftWithStart, input int shiftAt,
                         input int resetAt, input bit checkFirst);
    int cycles, accepted, stalls;
    bit finished, prevStall, rdy;
    logic [19:0] got, prev, expv;
    logic [2:0] h;
    sbQ.delete();
    pushFrame();
    hitPixCount = 0;
    start = 1'b1;
    if (shiftWithStart) begin
      shift = 1'b1; loop_mode = 1'b1;
      modelShift(1'b1, 3'b000, h);
    end
    @(negedge clock);
    start = 1'b0; shift = 1'b0;
    cycles = 1; accepted = 0; stalls = 0; finished = 0; prevStall = 0; prev = '0;
    checkVal("busy_start", busy, 1);
    while (!finished && cycles < 4*N) begin
      shift = 1'b0;
      got = {pix_x, pix_y, pix_colour};
      if (done) begin
        finished = 1;
        checkVal("done_cycle", cycles, N + 1 + stalls);
        checkVal("px_count", accepted, N);
        checkVal("done_idle", {busy, pix_valid}, 0);
        @(negedge clock);
        checkVal("done_pulse", done, 0);
      end else if (resetAt >= 0 && accepted == resetAt) begin
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkVal("rst_mid", {pix_valid, busy, done}, 0);
        mg = RST_PAT;
        sbQ.delete();
        repeat (3) begin
          @(negedge clock);
          checkVal("rst_no_done", {done, pix_valid}, 0);
        end
        finished = 1;
      end else begin
        checkVal("valid", pix_valid, 1);
        if (prevStall) checkVal("stable", got, prev);
        if (checkFirst && accepted == 0 && !prevStall)
          checkVal("first_px", got, {9'd0, 8'd120, 3'b000});
        rdy = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        pix_ready = rdy;
        if (rdy) begin
          if (sbQ.size() == 0) checkVal("sb_empty", 1, 0);
          else begin
            expv = sbQ.pop_front();
            checkVal("pixel", got, expv);
          end
          if (pix_colour == 3'b010) hitPixCount++;
          accepted++;
          if (shiftAt >= 0 && accepted == shiftAt) begin
            shift = 1'b1; loop_mode = 1'b1;
            modelShift(1'b1, 3'b000, h);
          end
        end else stalls++;
        prevStall = !rdy;
        prev = got;
        @(negedge clock);
        cycles++;
      end
    end
    if (!finished) checkVal("timeout", 0, 1);
    pix_ready = 1'b0; shift = 1'b0; loop_mode = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    mg = RST_PAT;
    @(negedge clock);
    checkVal("rst_outputs", {hit_notes, hit_valid, busy, done, pix_valid, pix_x, pix_y, pix_colour}, 0);
    checkVal("rst_busy", busy, 0);
    runDraw(1'b0, 1'b0, -1, -1, 1'b0);

    for (int i = 1; i <= 4; i++) begin
      doShift(1'b1, 3'b000, hGot);
      checkVal("loop_hit_lane0", hGot[0], (i == 3) ? 1 : 0);
    end
    checkVal("loop_hv_count", hvCount, 4);

    doShift(1'b0, 3'b101, hGot);
    for (int i = 2; i <= 5; i++) doShift(1'b0, 3'b000, hGot);
    checkVal("insert_hit5", hGot, 3'b101);
    checkVal("insert_hv_count", hvCount, 9);

    loadGrid(12'h080);
    runDraw(1'b0, 1'b0, -1, -1, 1'b1);
    checkVal("hit_pixels", hitPixCount, 64);
    runDraw(1'b1, 1'b0, -1, -1, 1'b1);
    checkVal("hit_pixels_bp", hitPixCount, 64);

    runDraw(1'b0, 1'b1, 200, -1, 1'b0);
    runDraw(1'b1, 1'b0, 100, 300, 1'b0);
    runDraw(1'b0, 1'b0, -1, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
